// File: rtl/mips_data_memory.sv
// mips_data_memory: word-addressed MIPS32 data memory with combinational loads and word/half/byte stores
module mips_data_memory #(
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = "data.mem"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_address,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  store_signal,
  output logic [31:0] read_data
);
  logic [31:0] data_mem [0:DEPTH-1];
  logic in_range;
  logic [ADDR_W-1:0] idx;
  logic [31:0] cur_word;
  logic [31:0] wr_word;
  logic wr_en;
  initial for (int i = 0; i < DEPTH; i++) data_mem[i] = 32'h0;
  assign in_range = mem_address < 32'(DEPTH);
  assign idx = mem_address[ADDR_W-1:0];
  assign cur_word = in_range ? data_mem[idx] : 32'h0;
  always_comb begin
    read_data = (mem_read && in_range && !reset) ? cur_word : 32'h0;
    wr_word = store_signal == 2'b01 ? {cur_word[31:16], write_data[15:0]} :
              store_signal == 2'b10 ? {cur_word[31:8], write_data[7:0]} : write_data;
    wr_en = mem_write && in_range && store_signal != 2'b11;
  end
  always_ff @(posedge clk)
    if (!reset && wr_en) data_mem[idx] <= wr_word;
endmodule

// File: tb/tb_mips_data_memory.sv
// tb_mips_data_memory: directed + randomized check of mips_data_memory against a behavioural word-array model
module tb_mips_data_memory;
   localparam int DEPTH = 256;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_address = 32'h0;
   logic [31:0] write_data = 32'h0;
   logic        mem_write = 1'b0;
   logic        mem_read = 1'b0;
   logic [1:0]  store_signal = 2'b00;
   logic [31:0] read_data;
   logic [31:0] model [0:DEPTH-1];
   int          errors = 0;
   int          checks = 0;
   bit          running = 1'b0;

   mips_data_memory #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .mem_address(mem_address), .write_data(write_data),
      .mem_write(mem_write), .mem_read(mem_read), .store_signal(store_signal), .read_data(read_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a store replaces the selected low bits of the addressed word.
   always @(posedge clk) begin
      if (!reset && mem_write && mem_address < DEPTH) begin
         case (store_signal)
            2'b00: model[mem_address] = write_data;
            2'b01: model[mem_address] = (model[mem_address] & 32'hFFFF0000) | (write_data & 32'h0000FFFF);
            2'b10: model[mem_address] = (model[mem_address] & 32'hFFFFFF00) | (write_data & 32'h000000FF);
            default: ;
         endcase
      end
   end

   // Every cycle: the load must equal the model word, or zero when disabled/out of range/in reset.
   always @(negedge clk) begin
      if (running)
         chk("read_data", read_data,
             (mem_read && !reset && mem_address < DEPTH) ? model[mem_address] : 32'h0);
   end

   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic mr,
                       input logic mw, input logic [1:0] ss, input logic rst);
      @(posedge clk);
      #1;
      mem_address = a; write_data = wd; mem_read = mr; mem_write = mw; store_signal = ss; reset = rst;
   endtask

   task automatic lit(input string nm, input logic [31:0] exp);
      @(negedge clk);
      #1;
      chk(nm, read_data, exp);
   endtask

   task automatic cmp_array(input string nm);
      for (int i = 0; i < DEPTH; i++) chk(nm, dut.data_mem[i], model[i]);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model[i] = $urandom;
         dut.data_mem[i] = model[i];
      end
      model[1] = 32'h12345678; dut.data_mem[1] = 32'h12345678;
      model[3] = 32'h33333333; dut.data_mem[3] = 32'h33333333;
      model[5] = 32'hAABBCCDD; dut.data_mem[5] = 32'hAABBCCDD;
      mem_address = 32'd1; mem_read = 1'b1;
      running = 1'b1;
      lit("reset_read", 32'h0);
      step(1, 0, 1, 0, 2'b00, 0);
      lit("preload_read", 32'h12345678);
      step(1, 32'hFDFFFFFF, 1, 1, 2'b00, 0);
      lit("same_cycle_old", 32'h12345678);
      step(1, 0, 1, 0, 2'b00, 0);
      lit("word_store", 32'hFDFFFFFF);
      step(5, 32'h00001111, 1, 1, 2'b01, 0);
      step(5, 32'h000000EE, 1, 1, 2'b10, 0);
      lit("half_store", 32'hAABB1111);
      step(5, 32'hFFFFFFFF, 1, 1, 2'b11, 0);
      lit("byte_store", 32'hAABB11EE);
      step(5, 0, 1, 0, 2'bxx, 0);
      lit("reserved_store", 32'hAABB11EE);
      step(5, 32'h0BADF00D, 0, 0, 2'bxx, 0);
      lit("no_read", 32'h0);
      step(3, 32'hDEADBEEF, 1, 1, 2'b00, 1);
      lit("reset_write", 32'h0);
      step(3, 0, 1, 0, 2'b00, 0);
      lit("after_reset", 32'h33333333);
      step(DEPTH, 32'hCAFEF00D, 1, 1, 2'b00, 0);
      lit("oor_read", 32'h0);
      step(32'h8000_0001, 32'hCAFEF00D, 1, 1, 2'b00, 0);
      step(1, 0, 1, 0, 2'b00, 0);
      lit("oor_upper", 32'hFDFFFFFF);
      cmp_array("mem_after_directed");
      for (int n = 0; n < 600; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom :
             ($urandom_range(0, 4) == 0) ? 32'($urandom_range(DEPTH - 4, DEPTH + 3)) :
             32'($urandom_range(0, 15));
         step(a, $urandom, 1'($urandom), 1'($urandom), 2'($urandom), $urandom_range(0, 19) == 0);
      end
      step(0, 0, 0, 0, 2'b00, 0);
      @(negedge clk);
      running = 1'b0;
      cmp_array("mem_final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
